sram_arbiter: RTL and testbench

Single-port SRAM arbiter between the frame decoder (real-time pixel reads for VGA) and the frame encoder (sprite writes during the render-clock low phase). It replaces the top-level `sram_writing` mux: the encoder no longer owns the bus for a whole window. Writes are queued in a small FIFO and slotted into cycles the decoder leaves free. Reads have priority, with a starvation guard for writes. The block drives the SRAM address, data and write-enable pins directly.

---
 rtl/sram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: decoder reads win, encoder writes queue in a FIFO
// and fill idle cycles; a starvation counter forces a write slot when reads hog the bus.

module sram_arbiter_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module sram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_STARVE = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rd_req,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  output logic [DATA_W-1:0]             o_rd_data,
  output logic                          o_rd_valid,
  output logic                          o_rd_drop,
  input  logic                          i_wr_valid,
  input  logic [ADDR_W-1:0]             i_wr_addr,
  input  logic [DATA_W-1:0]             i_wr_data,
  output logic                          o_wr_ready,
  output logic                          o_wr_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [ADDR_W-1:0]             o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0]             io_SRAM_DQ,
  output logic                          o_SRAM_WE_N
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_t;

  slot_t                    slot_d;
  slot_t                    slot_q;
  logic [CNT_W-1:0]         starve_cnt;
  logic [LVL_W-1:0]         level;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  logic                     push;
  logic                     pop;
  logic                     fifo_nonempty;
  logic                     force_wr;
  logic                     drop_q;
  logic                     dq_oe;
  logic [DATA_W-1:0]        dq_out;

  // Ready looks at level only: a full FIFO refuses a push even while popping.
  assign o_wr_ready    = (level != LVL_W'(FIFO_DEPTH));
  assign push          = i_wr_valid && o_wr_ready;
  assign pop           = (slot_d == SLOT_WRITE);
  assign fifo_nonempty = (level != '0);
  assign force_wr      = (starve_cnt == CNT_W'(MAX_STARVE));
  assign {head_addr, head_data} = head;

  sram_arbiter_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .push     (push),
    .push_dat ({i_wr_addr, i_wr_data}),
    .pop      (pop),
    .head_dat (head),
    .level    (level)
  );

  always_comb begin
    slot_d = SLOT_IDLE;
    if (fifo_nonempty && (!i_rd_req || force_wr)) slot_d = SLOT_WRITE;
    else if (i_rd_req && !force_wr)               slot_d = SLOT_READ;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q      <= SLOT_IDLE;
      starve_cnt  <= '0;
      o_SRAM_ADDR <= '0;
      o_SRAM_WE_N <= 1'b1;
      dq_oe       <= 1'b0;
      dq_out      <= '0;
      drop_q      <= 1'b0;
      o_rd_data   <= '0;
      o_rd_valid  <= 1'b0;
      o_rd_drop   <= 1'b0;
    end else begin
      slot_q <= slot_d;

      if (!fifo_nonempty || slot_d == SLOT_WRITE)
        starve_cnt <= '0;
      else if (slot_d == SLOT_READ && !force_wr)
        starve_cnt <= starve_cnt + CNT_W'(1);

      // Output enable moves with WE_N so DQ is released the cycle WE_N rises.
      case (slot_d)
        SLOT_WRITE: begin
          o_SRAM_ADDR <= head_addr;
          dq_out      <= head_data;
          o_SRAM_WE_N <= 1'b0;
          dq_oe       <= 1'b1;
        end
        SLOT_READ: begin
          o_SRAM_ADDR <= i_rd_addr;
          o_SRAM_WE_N <= 1'b1;
          dq_oe       <= 1'b0;
        end
        default: begin
          o_SRAM_WE_N <= 1'b1;
          dq_oe       <= 1'b0;
        end
      endcase

      drop_q     <= i_rd_req && (slot_d == SLOT_WRITE);
      o_rd_drop  <= drop_q;
      o_rd_valid <= (slot_q == SLOT_READ);
      if (slot_q == SLOT_READ) o_rd_data <= io_SRAM_DQ;
    end
  end

  assign io_SRAM_DQ   = dq_oe ? dq_out : {DATA_W{1'bz}};
  assign o_fifo_level = level;
  assign o_wr_empty   = (level == '0) && (slot_q != SLOT_WRITE);
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed table, hand sequences, and random traffic
// against a queue-based reference of the arbitration rules plus an SRAM model.

module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int MAXS = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          o_rd_drop;
  logic          o_wr_ready;
  logic          o_wr_empty;
  logic [LW-1:0] o_fifo_level;
  logic [AW-1:0] o_SRAM_ADDR;
  logic          o_SRAM_WE_N;
  wire  [DW-1:0] dq;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_STARVE(MAXS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_drop(o_rd_drop),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ready(o_wr_ready), .o_wr_empty(o_wr_empty), .o_fifo_level(o_fifo_level),
    .o_SRAM_ADDR(o_SRAM_ADDR), .io_SRAM_DQ(dq), .o_SRAM_WE_N(o_SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // External SRAM: drives DQ whenever WE_N is high, stores on a low WE_N edge.
  logic [DW-1:0] sram [logic [AW-1:0]];
  logic [AW-1:0] wlog [$];
  logic [DW-1:0] sram_rd = '0;
  assign dq = o_SRAM_WE_N ? sram_rd : {DW{1'bz}};

  function automatic logic [DW-1:0] sram_get(logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : '0;
  endfunction

  always @(posedge clk) begin
    if (!o_SRAM_WE_N) begin
      sram[o_SRAM_ADDR] = dq;
      wlog.push_back(o_SRAM_ADDR);
    end
  end
  always @(negedge clk) sram_rd = sram_get(o_SRAM_ADDR);

  // Reference model state
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           mq [$];
  logic [DW-1:0] mmem [logic [AW-1:0]];
  int            starve = 0;
  bit            pv = 0, pdrop = 0, m_acc = 0, m_gw = 0;
  logic [DW-1:0] pd = '0;

  function automatic logic [DW-1:0] mget(logic [AW-1:0] a);
    return mmem.exists(a) ? mmem[a] : '0;
  endfunction

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mmem.delete();
    sram.delete();
    wlog.delete();
    starve = 0;
    pv = 0;
    pdrop = 0;
  endtask

  // One clock: predict from the arbitration rules, advance, compare outputs.
  task automatic step();
    bit ne, frc, gw, gr, e_valid, e_drop, e_rdy, e_empty;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_addr;
    int e_lvl;
    wr_t h;
    ne  = (mq.size() > 0);
    frc = (starve == MAXS);
    gw  = ne && (!rd_req || frc);
    gr  = rd_req && !gw;
    e_valid = pv; e_data = pd; e_drop = pdrop;
    e_addr  = gw ? mq[0].a : rd_addr;
    m_acc = wr_valid && (mq.size() != DEPTH);
    m_gw  = gw;
    pv = gr;
    pd = mget(rd_addr);
    pdrop = rd_req && gw;
    if (!ne || gw) starve = 0;
    else if (gr && starve < MAXS) starve++;
    if (gw) begin
      h = mq.pop_front();
      mmem[h.a] = h.d;
    end
    if (m_acc) mq.push_back({wr_addr, wr_data});
    e_lvl   = mq.size();
    e_rdy   = (mq.size() != DEPTH);
    e_empty = (mq.size() == 0) && !gw;
    @(posedge clk);
    #1;
    cyc++;
    chk("rd_valid", o_rd_valid, e_valid);
    chk("rd_drop", o_rd_drop, e_drop);
    chk("we_n", o_SRAM_WE_N, !gw);
    chk("level", o_fifo_level, e_lvl);
    chk("wr_ready", o_wr_ready, e_rdy);
    chk("wr_empty", o_wr_empty, e_empty);
    if (e_valid) chk("rd_data", o_rd_data, e_data);
    if (gw || gr) chk("sram_addr", o_SRAM_ADDR, e_addr);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_we_n"}, o_SRAM_WE_N, 1);
    chk({tag, "_addr"}, o_SRAM_ADDR, 0);
    chk({tag, "_dq_released"}, dq, sram_rd);
    chk({tag, "_rd_data"}, o_rd_data, 0);
    chk({tag, "_rd_valid"}, o_rd_valid, 0);
    chk({tag, "_rd_drop"}, o_rd_drop, 0);
    chk({tag, "_level"}, o_fifo_level, 0);
    chk({tag, "_ready"}, o_wr_ready, 1);
    chk({tag, "_empty"}, o_wr_empty, 1);
  endtask

  typedef struct {
    logic rd; logic [AW-1:0] ra;
    logic wv; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic ev; logic [DW-1:0] ed; logic ewe; int elvl; logic erdy; logic eemp;
  } vec_t;
  vec_t tbl [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    int drops [$];
    int dens;

    // Read-only then mixed traffic, expectations derived by hand.
    tbl[0]  = '{1, 20'h10, 0, 20'h0,  16'h0,    0, 16'h0,    1, 0, 1, 1};
    tbl[1]  = '{1, 20'h11, 0, 20'h0,  16'h0,    1, 16'hA010, 1, 0, 1, 1};
    tbl[2]  = '{1, 20'h12, 0, 20'h0,  16'h0,    1, 16'hA011, 1, 0, 1, 1};
    tbl[3]  = '{1, 20'h13, 0, 20'h0,  16'h0,    1, 16'hA012, 1, 0, 1, 1};
    tbl[4]  = '{0, 20'h0,  0, 20'h0,  16'h0,    1, 16'hA013, 1, 0, 1, 1};
    tbl[5]  = '{0, 20'h0,  1, 20'h20, 16'h1111, 0, 16'h0,    1, 1, 1, 0};
    tbl[6]  = '{1, 20'h10, 1, 20'h21, 16'h2222, 0, 16'h0,    1, 2, 1, 0};
    tbl[7]  = '{0, 20'h0,  1, 20'h22, 16'h3333, 1, 16'hA010, 0, 2, 1, 0};
    tbl[8]  = '{1, 20'h20, 0, 20'h0,  16'h0,    0, 16'h0,    1, 2, 1, 0};
    tbl[9]  = '{0, 20'h0,  0, 20'h0,  16'h0,    1, 16'h1111, 0, 1, 1, 0};
    tbl[10] = '{1, 20'h21, 0, 20'h0,  16'h0,    0, 16'h0,    1, 1, 1, 0};
    tbl[11] = '{0, 20'h0,  0, 20'h0,  16'h0,    1, 16'h2222, 0, 0, 1, 0};
    tbl[12] = '{0, 20'h0,  0, 20'h0,  16'h0,    0, 16'h0,    1, 0, 1, 1};

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("init");
    rst_n = 1'b1;
    model_reset();

    for (int a = 16; a < 20; a++) begin
      sram[AW'(a)] = 16'hA000 + 16'(a);
      mmem[AW'(a)] = 16'hA000 + 16'(a);
    end
    for (int i = 0; i < 13; i++) begin
      rd_req = tbl[i].rd; rd_addr = tbl[i].ra;
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      step();
      chk($sformatf("tbl%0d_valid", i), o_rd_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), o_rd_data, tbl[i].ed);
      chk($sformatf("tbl%0d_we_n", i), o_SRAM_WE_N, tbl[i].ewe);
      chk($sformatf("tbl%0d_level", i), o_fifo_level, tbl[i].elvl);
      chk($sformatf("tbl%0d_ready", i), o_wr_ready, tbl[i].erdy);
      chk($sformatf("tbl%0d_empty", i), o_wr_empty, tbl[i].eemp);
    end

    // Write only: 8 back-to-back writes, one pop per cycle.
    wlog.delete();
    rd_req = 0;
    for (int k = 0; k < 8; k++) begin
      wr_valid = 1; wr_addr = 20'h100 + AW'(k); wr_data = DW'(k);
      step();
      chk("wo_level", o_fifo_level, 1);
    end
    wr_valid = 0;
    step();
    chk("wo_empty_1", o_wr_empty, 0);
    step();
    chk("wo_empty_2", o_wr_empty, 1);
    chk("wo_count", wlog.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < wlog.size()) chk("wo_order", wlog[k], 20'h100 + k);
      chk("wo_data", sram_get(20'h100 + AW'(k)), k);
    end

    // Backpressure and starvation under continuous reads.
    acc_n = 0;
    rd_req = 1; rd_addr = 20'h30;
    for (int t = 0; t < 37; t++) begin
      wr_valid = (acc_n < 9);
      wr_addr = 20'h140 + AW'(acc_n);
      wr_data = 16'h7000 + DW'(acc_n);
      step();
      if (m_acc) begin
        acc_n++;
        if (acc_n == 8) chk("bp_full_ready", o_wr_ready, 0);
        if (acc_n == 9) chk("bp_9th_accept_step", t, 18);
      end
      if (t == 12) chk("bp_held_ready", o_wr_ready, 0);
      if (o_rd_drop) begin
        drops.push_back(t);
        chk("drop_no_valid", o_rd_valid, 0);
      end
    end
    chk("drop_count", drops.size(), 2);
    chk("drop_first", drops.size() > 0 ? drops[0] : -1, 18);
    chk("drop_second", drops.size() > 1 ? drops[1] : -1, 35);
    rd_req = 0; wr_valid = 0;
    repeat (12) step();

    // Reset asserted in the middle of a write slot.
    wr_valid = 1; wr_addr = 20'h1F0; wr_data = 16'hBEEF;
    step();
    wr_addr = 20'h1F1;
    step();
    chk("rst_pre_we_n", o_SRAM_WE_N, 0);
    wr_valid = 0;
    #1 rst_n = 1'b0;
    #1 chk_reset("rst_async");
    @(posedge clk);
    #1 chk_reset("rst_hold");
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_valid", o_rd_valid, 0);
      chk("post_rst_empty", o_wr_empty, 1);
    end

    // Random traffic in three read densities; the last starves writes.
    for (int i = 0; i < 3000; i++) begin
      dens = (i / 500) % 3;
      rd_req   = ($urandom_range(0, 9) < (dens == 0 ? 3 : (dens == 1 ? 7 : 10)));
      rd_addr  = AW'($urandom_range(0, 31));
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr  = AW'($urandom_range(0, 31));
      wr_data  = DW'($urandom);
      step();
    end
    rd_req = 0; wr_valid = 0;
    repeat (12) step();
    for (int a = 0; a < 32; a++) chk($sformatf("mem_%0d", a), sram_get(AW'(a)), mget(AW'(a)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
